// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver.
//
// The divided scan clock (sclk_in) is treated as data: each rising edge seen on
// clk advances the digit index. The displayed value and decimal-point mask are
// captured into shadow registers only when the scan wraps back to digit 0, so a
// frame never mixes two values. All outputs are registered and active-low.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   sclk_in  divided scan clock, sampled as data
//   en       display enable (0 turns every anode off)
//   val      hex value, nibble i drives digit i (digit 0 = LSD)
//   dp_mask  bit i lights the decimal point of digit i
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   dp       decimal point, active-low
//   an       anodes, active-low, one-hot-low when enabled
module sseg_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk_in,
    input  logic                en,
    input  logic [4*DIGITS-1:0] val,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an
);

    localparam int unsigned     IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    logic                sclk_q;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    logic                tick;
    logic                wrap;

    logic [3:0]          nib;
    logic [DIGITS-1:0]   sel;
    logic                upper_zero;
    logic                blank;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Rising edge of the scan clock, one clk wide regardless of high time.
    assign tick = sclk_in & ~sclk_q;
    assign wrap = tick && (idx_q == LastIdx);

    // Scan index and wrap-time capture of the displayed value.
    always_comb begin
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IdxW'(1);
        end
        if (wrap) begin
            shadow_val_d = val;
            shadow_dp_d  = dp_mask;
        end
    end

    // Output stage works from the current (pre-update) index and shadows, so
    // the display trails the index by one clk.
    always_comb begin
        nib        = 4'h0;
        sel        = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i == int'(idx_q)) begin
                nib    = shadow_val_q[4*i +: 4];
                sel[i] = 1'b1;
            end
            // Current digit and everything above it must be zero to blank.
            if (i >= int'(idx_q) && shadow_val_q[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        blank = BLANK_LZ && (idx_q != '0) && upper_zero;
        seg_d = blank ? 7'h7F : decode(nib);
        dp_d  = ~|(shadow_dp_q & sel);
        an_d  = en ? ~sel : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q       <= 1'b0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            an           <= '1;
        end else begin
            sclk_q       <= sclk_in;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seg          <= seg_d;
            dp           <= dp_d;
            an           <= an_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver: two instances (leading-zero blanking
// on and off) share stimulus; a frame-level model predicts every output each
// clk, and directed literal checks pin the model to hand-computed values.
module tb_sseg_scan_driver;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk_in;
    logic        en;
    logic [15:0] val;
    logic [3:0]  dp_mask;

    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic [3:0]  an, an_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.DIGITS(D), .BLANK_LZ(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk_in (sclk_in),
        .en      (en),
        .val     (val),
        .dp_mask (dp_mask),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    sseg_scan_driver #(.DIGITS(D), .BLANK_LZ(1'b0)) dut_nb (
        .clk     (clk),
        .rst     (rst),
        .sclk_in (sclk_in),
        .en      (en),
        .val     (val),
        .dp_mask (dp_mask),
        .seg     (seg_nb),
        .dp      (dp_nb),
        .an      (an_nb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          m_ticks;
    bit          m_prev;
    logic [15:0] m_sv;
    logic [3:0]  m_sd;
    bit          m_valid = 1'b0;
    int          m_digit;
    logic [15:0] m_upper;
    logic [6:0]  e_seg, e_seg_nb;
    logic        e_dp;
    logic [3:0]  e_an;

    // Expected outputs after this edge come from the frame state before it.
    always @(posedge clk) begin
        if (rst) begin
            e_seg    = 7'h7F;
            e_seg_nb = 7'h7F;
            e_dp     = 1'b1;
            e_an     = 4'hF;
            m_ticks  = 0;
            m_prev   = 1'b0;
            m_sv     = '0;
            m_sd     = '0;
        end else begin
            m_digit  = m_ticks % D;
            m_upper  = m_sv >> (4 * m_digit);
            e_seg_nb = seg_tbl[m_upper[3:0]];
            e_seg    = (m_digit != 0 && m_upper == 16'h0) ? 7'h7F : e_seg_nb;
            e_dp     = ~m_sd[m_digit];
            e_an     = en ? ~(4'b0001 << m_digit) : 4'hF;
            if (sclk_in && !m_prev) begin
                m_ticks++;
                if (m_ticks % D == 0) begin
                    m_sv = val;
                    m_sd = dp_mask;
                end
            end
            m_prev = sclk_in;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("seg", seg, e_seg);
            check("dp", dp, e_dp);
            check("an", an, e_an);
            check("seg_nb", seg_nb, e_seg_nb);
            check("dp_nb", dp_nb, e_dp);
            check("an_nb", an_nb, e_an);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One scan tick; on return the outputs already show the new digit.
    task automatic tick;
        sclk_in = 1'b1;
        step(2);
        sclk_in = 1'b0;
        step(2);
    endtask

    task automatic expect_out(input string name, input logic [3:0] ea, input logic [6:0] es);
        check({name, "_an"}, an, ea);
        check({name, "_seg"}, seg, es);
    endtask

    initial begin
        rst     = 1'b1;
        sclk_in = 1'b0;
        en      = 1'b1;
        val     = 16'h1A3F;
        dp_mask = 4'b0000;
        step(1);
        // Reset held while sclk_in toggles.
        sclk_in = 1'b1;
        step(1);
        expect_out("rst0", 4'hF, 7'h7F);
        check("rst0_dp", dp, 1'b1);
        sclk_in = 1'b0;
        step(1);
        expect_out("rst1", 4'hF, 7'h7F);
        rst = 1'b0;
        step(1);
        expect_out("post_rst", 4'b1110, 7'h40);
        tick();
        expect_out("first_tick", 4'b1101, 7'h7F);

        // Scan and decode of 1A3F.
        tick();
        tick();
        tick();
        expect_out("scan_d0", 4'b1110, 7'h0E);
        tick();
        expect_out("scan_d1", 4'b1101, 7'h30);
        tick();
        expect_out("scan_d2", 4'b1011, 7'h08);
        tick();
        expect_out("scan_d3", 4'b0111, 7'h79);
        tick();
        expect_out("scan_rep", 4'b1110, 7'h0E);

        // Leading-zero blanking.
        val = 16'h0007;
        repeat (4) tick();
        expect_out("lz7_d0", 4'b1110, 7'h78);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("lz7_blank_seg", seg, 7'h7F);
            check("lz7_noblank_seg", seg_nb, 7'h40);
        end
        val = 16'h0000;
        tick();
        expect_out("lz0_d0", 4'b1110, 7'h40);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("lz0_blank_seg", seg, 7'h7F);
        end

        // Tear-free capture.
        val = 16'h1234;
        tick();
        expect_out("tf_d0", 4'b1110, 7'h19);
        tick();
        expect_out("tf_d1", 4'b1101, 7'h30);
        val = 16'h5678;
        tick();
        expect_out("tf_d2_old", 4'b1011, 7'h24);
        tick();
        expect_out("tf_d3_old", 4'b0111, 7'h79);
        tick();
        expect_out("tf_new_d0", 4'b1110, 7'h00);
        tick();
        expect_out("tf_new_d1", 4'b1101, 7'h78);
        tick();
        expect_out("tf_new_d2", 4'b1011, 7'h02);
        tick();
        expect_out("tf_new_d3", 4'b0111, 7'h12);

        // Enable off: anodes dark while the scan continues.
        en = 1'b0;
        tick();
        expect_out("en_off", 4'hF, 7'h00);
        tick();
        expect_out("en_off_adv", 4'hF, 7'h78);

        // Decimal point on digit 2 only (captured at next wrap).
        dp_mask = 4'b0100;
        en      = 1'b1;
        tick();
        tick();
        tick();
        check("dp_pre_wrap_d0", dp, 1'b1);
        tick();
        tick();
        expect_out("dp_d2", 4'b1011, 7'h02);
        check("dp_d2_lit", dp, 1'b0);
        tick();
        check("dp_d3_dark", dp, 1'b1);

        // Held sclk_in: exactly one advance.
        sclk_in = 1'b1;
        step(50);
        check("held_an", an, 4'b1110);
        sclk_in = 1'b0;
        step(2);
        check("held_release_an", an, 4'b1110);
        tick();
        check("held_next_an", an, 4'b1101);

        // Reset coinciding with a tick.
        sclk_in = 1'b1;
        rst     = 1'b1;
        step(2);
        expect_out("rst_tick", 4'hF, 7'h7F);
        check("rst_tick_dp", dp, 1'b1);
        rst     = 1'b0;
        sclk_in = 1'b0;
        step(2);
        expect_out("rst_tick_idx0", 4'b1110, 7'h40);
        tick();
        expect_out("rst_tick_next", 4'b1101, 7'h7F);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
